// File: rtl/booth_r4_accum.sv
// booth_r4_accum: radix-4 Booth multiplier that accumulates one serial Booth triple per cycle.
module booth_r4_accum #(
  parameter int MW = 8,
  localparam int PW = 2*MW,
  localparam int NGRP = MW/2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] mcand,
  input  logic [2:0]    grp,
  output logic [PW-1:0] product,
  output logic          busy,
  output logic          done
);
  localparam int CW = (NGRP > 1) ? $clog2(NGRP) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [MW-1:0] mc;
  logic [PW-1:0] acc, m, m2, pp, sum;
  logic [CW-1:0] cnt;
  logic last;
  always_comb begin
    m = {{MW{mc[MW-1]}}, mc};
    m2 = m << 1;
    pp = (grp == 3'b001 || grp == 3'b010) ? m :
         (grp == 3'b011) ? m2 :
         (grp == 3'b100) ? -m2 :
         (grp == 3'b101 || grp == 3'b110) ? -m : '0;
    sum = acc + (pp << {cnt, 1'b0});
    last = cnt == CW'(NGRP-1);
  end
  always_comb nxt = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (rst) begin
      mc <= '0;
      acc <= '0;
      cnt <= '0;
      product <= '0;
    end else if (state == RUN) begin
      acc <= sum;
      cnt <= cnt + CW'(1);
      if (last) product <= sum;
    end else if (start) begin
      mc <= mcand;
      acc <= '0;
      cnt <= '0;
    end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_booth_r4_accum.sv
// tb_booth_r4_accum: directed checks of the serial radix-4 Booth multiplier.
module tb_booth_r4_accum;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] mcand = 0;
  logic [2:0] grp = 0;
  logic [15:0] product;
  logic busy, done;
  int vecs = 0, errs = 0;

  booth_r4_accum #(.MW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand),
    .grp(grp), .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives start alongside the PISO load, then one Booth triple per cycle.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input int restart_at,
                        output logic [15:0] prod, output int busy_cyc, output int done_cnt);
    logic [8:0] ext;
    ext = {b, 1'b0};
    busy_cyc = 0;
    done_cnt = 0;
    start = 1;
    mcand = a;
    grp = 3'b011;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      grp = ext[2*i +: 3];
      start = (i == restart_at);
      if (start) mcand = 8'h64;
      tick();
    end
    if (done) done_cnt++;
    prod = product;
    start = 0;
    grp = 3'b011;
  endtask

  task automatic test_reset;
    logic [15:0] p;
    int bc, dc;
    rst = 1;
    start = 1;
    mcand = 8'h55;
    tick();
    tick();
    vecs++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset: product=%h busy=%b done=%b, required 0000 0 0", product, busy, done);
    end
    rst = 0;
    do_mul(8'd2, 8'd3, -1, p, bc, dc);
    vecs++;
    if (p !== 16'h0006) begin
      errs++;
      $display("FAIL start_after_reset: product=%h, required 0006", p);
    end
  endtask

  task automatic test_basic;
    logic [15:0] p;
    int bc, dc;
    do_mul(8'd7, 8'd3, -1, p, bc, dc);
    vecs++;
    if (p !== 16'h0015) begin
      errs++;
      $display("FAIL basic_product: product=%h, required 0015", p);
    end
    vecs++;
    if (bc != 4) begin
      errs++;
      $display("FAIL basic_busy: busy cycles=%0d, required 4", bc);
    end
    vecs++;
    if (dc != 1) begin
      errs++;
      $display("FAIL basic_done: done pulses=%0d, required 1", dc);
    end
    grp = 3'b100;
    tick();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h0015) begin
      errs++;
      $display("FAIL basic_idle: done=%b busy=%b product=%h, required 0 0 0015", done, busy, product);
    end
  endtask

  task automatic test_corner;
    logic [7:0] av[3] = '{8'h80, 8'h80, 8'h7F};
    logic [7:0] bv[3] = '{8'h80, 8'h7F, 8'hFF};
    logic [15:0] ev[3] = '{16'h4000, 16'hC080, 16'hFF81};
    logic [15:0] p;
    int bc, dc;
    for (int k = 0; k < 3; k++) begin
      do_mul(av[k], bv[k], -1, p, bc, dc);
      vecs++;
      if (p !== ev[k]) begin
        errs++;
        $display("FAIL corner_%0d: %h*%h product=%h, required %h", k, av[k], bv[k], p, ev[k]);
      end
      tick();
    end
  endtask

  task automatic test_zero_sign;
    logic [15:0] p;
    int bc, dc;
    do_mul(8'h00, 8'h5A, -1, p, bc, dc);
    vecs++;
    if (p !== 16'h0000) begin
      errs++;
      $display("FAIL zero: product=%h, required 0000", p);
    end
    tick();
    do_mul(8'hFF, 8'hFF, -1, p, bc, dc);
    vecs++;
    if (p !== 16'h0001) begin
      errs++;
      $display("FAIL neg_neg: product=%h, required 0001", p);
    end
    tick();
  endtask

  task automatic test_start_busy;
    logic [15:0] p;
    int bc, dc;
    do_mul(8'd7, 8'd3, 1, p, bc, dc);
    vecs++;
    if (p !== 16'h0015) begin
      errs++;
      $display("FAIL start_busy_product: product=%h, required 0015", p);
    end
    vecs++;
    if (dc != 1 || bc != 4) begin
      errs++;
      $display("FAIL start_busy_pulse: done=%0d busy=%0d, required 1 4", dc, bc);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL start_busy_after: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p1, p2;
    int bc1, dc1, bc2, dc2;
    do_mul(8'd7, 8'd3, -1, p1, bc1, dc1);
    do_mul(8'hFB, 8'd9, -1, p2, bc2, dc2);
    vecs++;
    if (p1 !== 16'h0015) begin
      errs++;
      $display("FAIL b2b_first: product=%h, required 0015", p1);
    end
    vecs++;
    if (p2 !== 16'hFFD3) begin
      errs++;
      $display("FAIL b2b_second: product=%h, required ffd3", p2);
    end
    vecs++;
    if (bc2 != 4 || dc2 != 1) begin
      errs++;
      $display("FAIL b2b_timing: busy=%0d done=%0d, required 4 1", bc2, dc2);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] p;
    int bc, dc, seen;
    tick();
    start = 1;
    mcand = 8'd7;
    tick();
    start = 0;
    grp = 3'b110;
    tick();
    rst = 1;
    grp = 3'b001;
    tick();
    vecs++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: product=%h busy=%b done=%b, required 0000 0 0", product, busy, done);
    end
    rst = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) seen++;
    end
    vecs++;
    if (seen != 0) begin
      errs++;
      $display("FAIL reset_mid_quiet: active cycles=%0d, required 0", seen);
    end
    do_mul(8'd5, 8'd5, -1, p, bc, dc);
    vecs++;
    if (p !== 16'h0019) begin
      errs++;
      $display("FAIL reset_mid_restart: product=%h, required 0019", p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_corner();
    test_zero_sign();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
